// File: rtl/interdevice_link_hub.sv
`default_nettype none
// ============================================================================
//  Module   : interdevice_link_hub
//  Purpose  : Bridges the router-side flit stream to NUM_LINKS direct device
//             links. TX flits are buffered and broadcast to every link, and
//             retire once all links have taken them. RX flits are picked
//             round-robin, filtered on checksum and destination, then
//             buffered. Drops are counted per reason.
//  Flit     : {dst_id[NODE_ID_W], payload[PAYLOAD_W], checksum[CSUM_W]}
//             checksum = XOR-fold of {dst_id, payload} in CSUM_W-bit chunks,
//             starting at bit 0 and zero-padding the top chunk.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  ilh_fifo : pointer-compare FIFO with wrap bit, registered storage
// ----------------------------------------------------------------------------
module ilh_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);
   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW:0]    r_wr_ptr;
   logic [c_AW:0]    r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Full when the wrap bits differ but the index bits match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   // No bypass: a full FIFO refuses a push even when popping this cycle.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_dout    = r_mem[r_rd_ptr[c_AW-1:0]];

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
      end
   end

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// ----------------------------------------------------------------------------
//  interdevice_link_hub : top level
// ----------------------------------------------------------------------------
module interdevice_link_hub #(
   parameter int                    NUM_LINKS     = 2,
   parameter int                    TX_FIFO_DEPTH = 4,
   parameter int                    RX_FIFO_DEPTH = 4,
   parameter int                    NODE_ID_W     = 4,
   parameter int                    PAYLOAD_W     = 20,
   parameter int                    CSUM_W        = 8,
   parameter logic [NODE_ID_W-1:0]  BROADCAST_ID  = '1,
   parameter int                    CNT_WIDTH     = 16,
   localparam int                   FLIT_W        = NODE_ID_W + PAYLOAD_W + CSUM_W
) (
   input  logic                             cpuclk,
   input  logic                             rst,
   input  logic [NODE_ID_W-1:0]             this_node_id,
   // router -> hub
   input  logic [FLIT_W-1:0]                interdevice_tx_flit,
   input  logic                             interdevice_tx_valid,
   output logic                             interdevice_tx_ready,
   // hub -> router
   output logic [FLIT_W-1:0]                interdevice_rx_flit,
   output logic                             interdevice_rx_valid,
   input  logic                             interdevice_rx_ready,
   // links -> hub
   input  logic [NUM_LINKS-1:0][FLIT_W-1:0] flit_rx,
   input  logic [NUM_LINKS-1:0]             flit_rx_valid,
   output logic [NUM_LINKS-1:0]             flit_rx_ready,
   // hub -> links
   output logic [FLIT_W-1:0]                flit_tx,
   output logic [NUM_LINKS-1:0]             flit_tx_valid,
   input  logic [NUM_LINKS-1:0]             flit_tx_ready,
   // drop statistics
   output logic [CNT_WIDTH-1:0]             drop_checksum_count,
   output logic [CNT_WIDTH-1:0]             drop_dst_count
);
   localparam int c_LINK_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
   localparam int c_HDR_W  = FLIT_W - CSUM_W;

   // Checksum over the header: XOR of CSUM_W-bit chunks from bit 0 upward.
   function automatic logic [CSUM_W-1:0] calculate_checksum_comb(
      input logic [c_HDR_W-1:0] i_hdr
   );
      logic [CSUM_W-1:0] v_acc;
      v_acc = '0;
      for (int c = 0; c < c_HDR_W; c += CSUM_W) begin
         v_acc = v_acc ^ CSUM_W'(i_hdr >> c);
      end
      return v_acc;
   endfunction

   // Link index plus offset, wrapped modulo NUM_LINKS.
   function automatic logic [c_LINK_W-1:0] f_link_wrap(
      input logic [c_LINK_W-1:0] i_base,
      input int                  i_off
   );
      int v_sum;
      v_sum = int'(i_base) + i_off;
      if (v_sum >= NUM_LINKS) v_sum = v_sum - NUM_LINKS;
      return c_LINK_W'(v_sum);
   endfunction

   // ------------------------------------------------------------------ TX --
   logic                 w_tx_full;
   logic                 w_tx_empty;
   logic                 w_tx_push;
   logic                 w_tx_pop;
   logic [FLIT_W-1:0]    w_tx_head;
   logic [NUM_LINKS-1:0] w_tx_valid;
   logic [NUM_LINKS-1:0] w_tx_done;
   logic [NUM_LINKS-1:0] r_sent_mask;

   assign interdevice_tx_ready = !w_tx_full && !rst;
   assign w_tx_push            = interdevice_tx_valid && interdevice_tx_ready;
   // A link that already took the head stays quiet until the next head.
   assign w_tx_valid           = (!w_tx_empty && !rst) ? ~r_sent_mask : '0;
   assign w_tx_done            = r_sent_mask | (w_tx_valid & flit_tx_ready);
   assign w_tx_pop             = !w_tx_empty && (&w_tx_done);
   assign flit_tx              = w_tx_head;
   assign flit_tx_valid        = w_tx_valid;

   ilh_fifo #(
      .DEPTH (TX_FIFO_DEPTH),
      .WIDTH (FLIT_W)
   ) u_tx_fifo (
      .clk     (cpuclk),
      .rst     (rst),
      .i_push  (w_tx_push),
      .i_din   (interdevice_tx_flit),
      .i_pop   (w_tx_pop),
      .o_dout  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

   // Track which links have accepted the current head; clear on retirement.
   always_ff @(posedge cpuclk) begin
      if (rst) begin
         r_sent_mask <= '0;
      end else if (&w_tx_done) begin
         r_sent_mask <= '0;
      end else begin
         r_sent_mask <= w_tx_done;
      end
   end

   // ------------------------------------------------------------------ RX --
   logic [c_LINK_W-1:0]  r_rr_ptr;
   logic [c_LINK_W-1:0]  w_grant;
   logic                 w_any_valid;
   logic                 w_rx_full;
   logic                 w_rx_empty;
   logic                 w_rx_hs;
   logic                 w_rx_push;
   logic                 w_rx_pop;
   logic [FLIT_W-1:0]    w_sel_flit;
   logic [NODE_ID_W-1:0] w_sel_dst;
   logic                 w_csum_ok;
   logic                 w_dst_ok;
   logic [NUM_LINKS-1:0] w_rx_ready_vec;
   logic [CNT_WIDTH-1:0] r_drop_csum;
   logic [CNT_WIDTH-1:0] r_drop_dst;

   // Round-robin search: first valid link at or above r_rr_ptr, with wrap.
   always_comb begin
      w_grant     = '0;
      w_any_valid = 1'b0;
      for (int k = 0; k < NUM_LINKS; k++) begin
         if (!w_any_valid && flit_rx_valid[f_link_wrap(r_rr_ptr, k)]) begin
            w_any_valid = 1'b1;
            w_grant     = f_link_wrap(r_rr_ptr, k);
         end
      end
   end

   // Dropped flits are still handshaken, so the filter only gates the push.
   assign w_rx_hs    = w_any_valid && !w_rx_full && !rst;
   assign w_sel_flit = flit_rx[w_grant];
   assign w_sel_dst  = w_sel_flit[FLIT_W-1 -: NODE_ID_W];
   assign w_csum_ok  = (calculate_checksum_comb(w_sel_flit[FLIT_W-1:CSUM_W]) ==
                        w_sel_flit[CSUM_W-1:0]);
   assign w_dst_ok   = (w_sel_dst == this_node_id) || (w_sel_dst == BROADCAST_ID);
   assign w_rx_push  = w_rx_hs && w_csum_ok && w_dst_ok;
   assign w_rx_pop   = interdevice_rx_valid && interdevice_rx_ready;

   // Only the granted link sees ready.
   always_comb begin
      w_rx_ready_vec = '0;
      if (w_rx_hs) w_rx_ready_vec[w_grant] = 1'b1;
   end
   assign flit_rx_ready = w_rx_ready_vec;

   ilh_fifo #(
      .DEPTH (RX_FIFO_DEPTH),
      .WIDTH (FLIT_W)
   ) u_rx_fifo (
      .clk     (cpuclk),
      .rst     (rst),
      .i_push  (w_rx_push),
      .i_din   (w_sel_flit),
      .i_pop   (w_rx_pop),
      .o_dout  (interdevice_rx_flit),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   assign interdevice_rx_valid = !w_rx_empty && !rst;

   // Advance the round-robin pointer past the link just served.
   always_ff @(posedge cpuclk) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_rx_hs) begin
         r_rr_ptr <= f_link_wrap(w_grant, 1);
      end
   end

   // Saturating drop counters; checksum failures take precedence.
   always_ff @(posedge cpuclk) begin
      if (rst) begin
         r_drop_csum <= '0;
         r_drop_dst  <= '0;
      end else if (w_rx_hs) begin
         if (!w_csum_ok) begin
            if (r_drop_csum != '1) r_drop_csum <= r_drop_csum + 1'b1;
         end else if (!w_dst_ok) begin
            if (r_drop_dst != '1) r_drop_dst <= r_drop_dst + 1'b1;
         end
      end
   end

   assign drop_checksum_count = r_drop_csum;
   assign drop_dst_count      = r_drop_dst;
endmodule
`default_nettype wire

// File: tb/tb_interdevice_link_hub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interdevice_link_hub
//  Purpose  : Randomised bench for interdevice_link_hub with a queue-based
//             reference model of broadcast, arbitration, filtering and
//             drop statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interdevice_link_hub;
   localparam int        NL     = 2;
   localparam int        DEPTH  = 4;
   localparam int        CW     = 3;
   localparam int        FW     = 32;
   localparam int        CMAX   = 7;
   localparam logic [3:0] MY_ID = 4'h5;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         node_id;
   logic [FW-1:0]      tx_flit_in;
   logic               tx_valid_in;
   logic               tx_ready_out;
   logic [FW-1:0]      rx_flit_out;
   logic               rx_valid_out;
   logic               rx_ready_in;
   logic [NL-1:0][FW-1:0] link_rx;
   logic [NL-1:0]      link_rx_valid;
   logic [NL-1:0]      link_rx_ready;
   logic [FW-1:0]      link_tx;
   logic [NL-1:0]      link_tx_valid;
   logic [NL-1:0]      link_tx_ready;
   logic [CW-1:0]      cnt_csum;
   logic [CW-1:0]      cnt_dst;

   always #5 clk = ~clk;

   interdevice_link_hub #(
      .NUM_LINKS     (NL),
      .TX_FIFO_DEPTH (DEPTH),
      .RX_FIFO_DEPTH (DEPTH),
      .CNT_WIDTH     (CW)
   ) dut (
      .cpuclk               (clk),
      .rst                  (rst),
      .this_node_id         (node_id),
      .interdevice_tx_flit  (tx_flit_in),
      .interdevice_tx_valid (tx_valid_in),
      .interdevice_tx_ready (tx_ready_out),
      .interdevice_rx_flit  (rx_flit_out),
      .interdevice_rx_valid (rx_valid_out),
      .interdevice_rx_ready (rx_ready_in),
      .flit_rx              (link_rx),
      .flit_rx_valid        (link_rx_valid),
      .flit_rx_ready        (link_rx_ready),
      .flit_tx              (link_tx),
      .flit_tx_valid        (link_tx_valid),
      .flit_tx_ready        (link_tx_ready),
      .drop_checksum_count  (cnt_csum),
      .drop_dst_count       (cnt_dst)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Flit kinds: 0 good/self, 1 good/broadcast, 2 good/foreign,
   // 3 bad checksum/random dst, 4 bad checksum/foreign dst.
   function automatic logic [FW-1:0] mk_flit(input int kind);
      logic [3:0]  d;
      logic [19:0] p;
      logic [23:0] h;
      logic [7:0]  c;
      p = 20'($urandom);
      case (kind)
         0:       d = MY_ID;
         1:       d = 4'hF;
         2, 4:    d = MY_ID + 4'd1;
         default: d = 4'($urandom);
      endcase
      h = {d, p};
      c = h[23:16] ^ h[15:8] ^ h[7:0];
      if (kind >= 3) c = c ^ (8'd1 << $urandom_range(7, 0));
      return {h, c};
   endfunction

   function automatic int rand_kind();
      int r;
      r = $urandom_range(9, 0);
      if (r < 5) return 0;
      if (r < 6) return 1;
      if (r < 8) return 2;
      return (r == 8) ? 3 : 4;
   endfunction

   // ---------------------------------------------------------- reference --
   logic [FW-1:0] m_txq[$];
   bit            m_acc[NL];
   logic [FW-1:0] m_rxq[$];
   int            m_last;
   int            m_cc;
   int            m_dc;
   logic [NL-1:0] m_ev;
   logic [NL-1:0] m_erdy;
   int            m_g;
   bit            m_found;
   bit            m_all;
   int            m_txsz;
   logic [FW-1:0] m_f;
   logic [23:0]   m_h;

   always @(negedge clk) begin
      if (rst) begin
         check_eq("rst_tx_ready", tx_ready_out, 0);
         check_eq("rst_tx_valid", link_tx_valid, 0);
         check_eq("rst_rx_ready", link_rx_ready, 0);
         check_eq("rst_rx_valid", rx_valid_out, 0);
         m_txq.delete();
         m_rxq.delete();
         for (int i = 0; i < NL; i++) m_acc[i] = 0;
         m_last = NL - 1;
         m_cc   = 0;
         m_dc   = 0;
      end else begin
         m_txsz = m_txq.size();
         for (int i = 0; i < NL; i++) m_ev[i] = (m_txsz > 0) && !m_acc[i];
         check_eq("tx_ready", tx_ready_out, m_txsz < DEPTH);
         check_eq("tx_valid", link_tx_valid, m_ev);
         if (m_txsz > 0) check_eq("tx_flit", link_tx, m_txq[0]);

         m_found = 0;
         m_g     = 0;
         for (int k = 1; k <= NL; k++) begin
            if (!m_found && link_rx_valid[(m_last + k) % NL]) begin
               m_found = 1;
               m_g     = (m_last + k) % NL;
            end
         end
         m_erdy = '0;
         if (m_found && m_rxq.size() < DEPTH) m_erdy[m_g] = 1'b1;
         check_eq("rx_ready", link_rx_ready, m_erdy);
         check_eq("rx_valid", rx_valid_out, m_rxq.size() > 0);
         if (m_rxq.size() > 0) check_eq("rx_flit", rx_flit_out, m_rxq[0]);
         check_eq("drop_csum", cnt_csum, m_cc);
         check_eq("drop_dst", cnt_dst, m_dc);

         // advance the model to the state after the coming edge
         if (m_rxq.size() > 0 && rx_ready_in) void'(m_rxq.pop_front());
         if (m_erdy != 0) begin
            m_last = m_g;
            m_f    = link_rx[m_g];
            m_h    = m_f[31:8];
            if ((m_h[23:16] ^ m_h[15:8] ^ m_h[7:0]) != m_f[7:0]) begin
               if (m_cc < CMAX) m_cc++;
            end else if (m_f[31:28] != MY_ID && m_f[31:28] != 4'hF) begin
               if (m_dc < CMAX) m_dc++;
            end else begin
               m_rxq.push_back(m_f);
            end
         end
         for (int i = 0; i < NL; i++) if (m_ev[i] && link_tx_ready[i]) m_acc[i] = 1;
         m_all = 1;
         for (int i = 0; i < NL; i++) if (!m_acc[i]) m_all = 0;
         if (m_txsz > 0 && m_all) begin
            void'(m_txq.pop_front());
            for (int i = 0; i < NL; i++) m_acc[i] = 0;
         end
         if (tx_valid_in && m_txsz < DEPTH) m_txq.push_back(tx_flit_in);
      end
   end

   // ----------------------------------------------------------- stimulus --
   task automatic cyc(input logic r, input logic txv, input logic [FW-1:0] txf,
                      input logic [NL-1:0] ltr, input logic [NL-1:0] lrv,
                      input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                      input logic rxr);
      @(posedge clk);
      #1;
      rst           = r;
      tx_valid_in   = txv;
      tx_flit_in    = txf;
      link_tx_ready = ltr;
      link_rx_valid = lrv;
      link_rx[0]    = f0;
      link_rx[1]    = f1;
      rx_ready_in   = rxr;
   endtask

   initial begin
      rst           = 1'b1;
      node_id       = MY_ID;
      tx_valid_in   = 1'b0;
      tx_flit_in    = '0;
      link_tx_ready = '0;
      link_rx_valid = '0;
      link_rx       = '0;
      rx_ready_in   = 1'b0;
      repeat (3) cyc(1, 0, '0, '0, '0, '0, '0, 0);

      // staggered broadcast: link0 ready at once, link1 three cycles later
      cyc(0, 1, 32'hA1A1_0001, 2'b01, '0, '0, '0, 1);
      cyc(0, 1, 32'hB2B2_0002, 2'b01, '0, '0, '0, 1);
      cyc(0, 0, '0, 2'b01, '0, '0, '0, 1);
      cyc(0, 0, '0, 2'b01, '0, '0, '0, 1);
      repeat (4) cyc(0, 0, '0, 2'b11, '0, '0, '0, 1);

      // TX full: links stalled while the source keeps pushing
      for (int n = 0; n < 6; n++) cyc(0, 1, $urandom, 2'b00, '0, '0, '0, 1);
      repeat (6) cyc(0, 0, '0, 2'b11, '0, '0, '0, 1);

      // RX fairness: both links continuously valid
      for (int n = 0; n < 8; n++) cyc(0, 0, '0, 2'b11, 2'b11, mk_flit(0), mk_flit(0), 1);

      // RX backpressure, then a single router pop
      for (int n = 0; n < 8; n++) cyc(0, 0, '0, 2'b11, 2'b11, mk_flit(0), mk_flit(0), 0);
      cyc(0, 0, '0, 2'b11, 2'b11, mk_flit(0), mk_flit(0), 1);
      for (int n = 0; n < 3; n++) cyc(0, 0, '0, 2'b11, 2'b11, mk_flit(0), mk_flit(0), 0);
      repeat (6) cyc(0, 0, '0, 2'b11, '0, '0, '0, 1);

      // filter sequence on link0
      cyc(0, 0, '0, 2'b11, 2'b01, mk_flit(3), '0, 1);
      cyc(0, 0, '0, 2'b11, 2'b01, mk_flit(2), '0, 1);
      cyc(0, 0, '0, 2'b11, 2'b01, mk_flit(1), '0, 1);
      cyc(0, 0, '0, 2'b11, 2'b01, mk_flit(4), '0, 1);
      repeat (2) cyc(0, 0, '0, 2'b11, '0, '0, '0, 1);

      // drive both counters into saturation
      for (int n = 0; n < 12; n++) cyc(0, 0, '0, 2'b11, 2'b11, mk_flit(3), mk_flit(2), 1);

      // reset with two TX entries and link0 already served
      cyc(0, 1, $urandom, 2'b00, '0, '0, '0, 1);
      cyc(0, 1, $urandom, 2'b01, '0, '0, '0, 1);
      cyc(0, 0, '0, 2'b00, '0, '0, '0, 1);
      cyc(1, 0, '0, 2'b11, '0, '0, '0, 1);
      repeat (4) cyc(0, 0, '0, 2'b11, '0, '0, '0, 1);

      // long random run with occasional resets and varying router pressure
      for (int n = 0; n < 1500; n++) begin
         cyc(($urandom_range(149, 0) == 0), 1'($urandom), $urandom,
             NL'($urandom), NL'($urandom), mk_flit(rand_kind()), mk_flit(rand_kind()),
             ((n / 150) % 2 == 1) ? ($urandom_range(9, 0) < 3) : ($urandom_range(9, 0) < 8));
      end
      repeat (2) cyc(0, 0, '0, 2'b11, '0, '0, '0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
